// File: rtl/cmos_gray_window_packer.sv
// Crops a window from the 8-bit CMOS gray stream and packs 4 pixels per word.
// Frame start/done/error pulses, sticky overflow and a completed-frame count.
module cmos_gray_window_packer #(
    parameter int X_START    = 0,
    parameter int Y_START    = 0,
    parameter int WIN_WIDTH  = 640,
    parameter int WIN_HEIGHT = 480
) (
    input  logic        i_cmos_pclk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_frame_vsync,
    input  logic        i_frame_href,
    input  logic [7:0]  i_frame_data,
    input  logic        i_fifo_afull,
    input  logic        i_ovf_clr,
    output logic        o_wr_en,
    output logic [31:0] o_wr_data,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_overflow,
    output logic [15:0] o_frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DROP
    } state_t;

    localparam logic [31:0] X_LO = 32'(X_START);
    localparam logic [31:0] X_HI = 32'(X_START + WIN_WIDTH);
    localparam logic [31:0] Y_LO = 32'(Y_START);
    localparam logic [31:0] Y_HI = 32'(Y_START + WIN_HEIGHT);

    state_t      state;
    logic        vs_prev;
    logic        href_prev;
    logic [11:0] col;
    logic [11:0] row;
    logic [1:0]  lane;
    logic [23:0] pack;

    logic        vs_rise;
    logic        vs_fall;
    logic        href_fall;
    logic        valid;
    logic        col_in;
    logic        row_in;
    logic        keep;
    logic        word_done;
    logic        rows_done;

    assign vs_rise   = i_frame_vsync & ~vs_prev;
    assign vs_fall   = ~i_frame_vsync & vs_prev;
    assign href_fall = ~i_frame_href & href_prev;
    assign valid     = i_frame_href & i_frame_vsync;

    // Window membership uses 32-bit compares so X/Y end never wrap.
    assign col_in    = ({20'd0, col} >= X_LO) && ({20'd0, col} < X_HI);
    assign row_in    = ({20'd0, row} >= Y_LO) && ({20'd0, row} < Y_HI);
    assign rows_done = {20'd0, row} >= Y_HI;

    assign keep      = valid && col_in && row_in && (state == CAPTURE);
    assign word_done = keep && (lane == 2'd3);

    // Previous samples of vsync/href for same-cycle edge detection.
    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_prev   <= 1'b0;
            href_prev <= 1'b0;
        end else begin
            vs_prev   <= i_frame_vsync;
            href_prev <= i_frame_href;
        end
    end

    // Column and row position of the current sample within the frame.
    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col <= 12'd0;
            row <= 12'd0;
        end else begin
            if (!i_frame_href) begin
                col <= 12'd0;
            end else if (valid) begin
                col <= col + 12'd1;
            end
            if (vs_rise) begin
                row <= 12'd0;
            end else if (href_fall && i_frame_vsync) begin
                row <= row + 12'd1;
            end
        end
    end

    // Lane index and the three lower lanes of the word being assembled.
    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane <= 2'd0;
            pack <= 24'd0;
        end else if (vs_rise || href_fall) begin
            lane <= 2'd0;
        end else if (keep) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    pack[7:0]   <= i_frame_data;
                2'd1:    pack[15:8]  <= i_frame_data;
                2'd2:    pack[23:16] <= i_frame_data;
                default: pack        <= pack;
            endcase
        end
    end

    // Frame FSM with registered write strobe, pulses, overflow and count.
    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_wr_en       <= 1'b0;
            o_wr_data     <= 32'd0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overflow    <= 1'b0;
            o_frame_cnt   <= 16'd0;
        end else begin
            o_wr_en       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_err   <= 1'b0;
            if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!i_frame_vsync) begin
                        state <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (vs_rise && i_enable) begin
                        state         <= CAPTURE;
                        o_frame_start <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (vs_fall) begin
                        state <= WAIT_VS;
                        if (rows_done) begin
                            o_frame_done <= 1'b1;
                            o_frame_cnt  <= o_frame_cnt + 16'd1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else if (word_done) begin
                        if (i_fifo_afull) begin
                            o_overflow <= 1'b1;
                            state      <= DROP;
                        end else begin
                            o_wr_en   <= 1'b1;
                            o_wr_data <= {i_frame_data, pack};
                        end
                    end
                end
                DROP: begin
                    if (vs_fall) begin
                        o_frame_err <= 1'b1;
                        state       <= WAIT_VS;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_gray_window_packer.sv
// Randomised and directed frames for cmos_gray_window_packer.
// Expected words and pulses come from a per-frame behavioural model.
module tb_cmos_gray_window_packer;

    localparam int XS = 2;
    localparam int YS = 1;
    localparam int WW = 8;
    localparam int WH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic        i_frame_vsync;
    logic        i_frame_href;
    logic [7:0]  i_frame_data;
    logic        i_fifo_afull;
    logic        i_ovf_clr;
    logic        o_wr_en;
    logic [31:0] o_wr_data;
    logic        o_frame_start;
    logic        o_frame_done;
    logic        o_frame_err;
    logic        o_overflow;
    logic [15:0] o_frame_cnt;

    cmos_gray_window_packer #(
        .X_START   (XS),
        .Y_START   (YS),
        .WIN_WIDTH (WW),
        .WIN_HEIGHT(WH)
    ) dut (
        .i_cmos_pclk  (clk),
        .i_rst_n      (rst_n),
        .i_enable     (i_enable),
        .i_frame_vsync(i_frame_vsync),
        .i_frame_href (i_frame_href),
        .i_frame_data (i_frame_data),
        .i_fifo_afull (i_fifo_afull),
        .i_ovf_clr    (i_ovf_clr),
        .o_wr_en      (o_wr_en),
        .o_wr_data    (o_wr_data),
        .o_frame_start(o_frame_start),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err),
        .o_overflow   (o_overflow),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_start = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          lat_cyc = 0;
    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic [31:0] exp_q[$];
    bit          e_start;
    bit          e_done;
    bit          e_err;
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_ovf = 1'b0;
    logic [7:0]  pix[0:7][0:15];
    bit          afl[0:7][0:15];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_wr_en) begin
            got_q.push_back(o_wr_data);
            got_cyc.push_back(cyc);
        end
        if (o_frame_start) n_start++;
        if (o_frame_done) n_done++;
        if (o_frame_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_pattern(input int nr, input int nc);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) begin
                pix[r][c] = 8'(r * 16 + c);
                afl[r][c] = 1'b0;
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) begin
                pix[r][c] = 8'($urandom);
                afl[r][c] = ($urandom_range(0, 24) == 0);
            end
    endtask

    // Window crop and 4-pixel packing computed directly from the frame.
    task automatic model_frame(input int nr, input int nc, input bit en);
        logic [31:0] w;
        int          lanes;
        bit          dropped;
        exp_q.delete();
        e_start = 0;
        e_done  = 0;
        e_err   = 0;
        if (!en) return;
        e_start = 1;
        dropped = 0;
        for (int r = 0; r < nr; r++) begin
            lanes = 0;
            w = 32'd0;
            for (int c = 0; c < nc; c++) begin
                if (c >= XS && c < XS + WW && r >= YS && r < YS + WH) begin
                    w[lanes*8 +: 8] = pix[r][c];
                    lanes++;
                    if (lanes == 4) begin
                        lanes = 0;
                        if (!dropped) begin
                            if (afl[r][c]) begin
                                dropped = 1;
                                exp_ovf = 1'b1;
                            end else begin
                                exp_q.push_back(w);
                            end
                        end
                    end
                end
            end
        end
        if (dropped) e_err = 1;
        else if (nr >= YS + WH) begin
            e_done = 1;
            exp_cnt = exp_cnt + 16'd1;
        end else e_err = 1;
    endtask

    task automatic drive_frame(input int nr, input int nc, input bit en,
                               input bit en_late);
        i_enable = en;
        i_frame_vsync = 1'b1;
        tick(3);
        for (int r = 0; r < nr; r++) begin
            i_frame_href = 1'b1;
            for (int c = 0; c < nc; c++) begin
                i_frame_data = pix[r][c];
                i_fifo_afull = afl[r][c];
                if (r == 1 && c == 5) lat_cyc = cyc;
                tick();
            end
            i_frame_href = 1'b0;
            i_fifo_afull = 1'b0;
            i_frame_data = 8'd0;
            if (en_late && r == 0) i_enable = 1'b1;
            tick(3);
        end
        tick(2);
        i_frame_vsync = 1'b0;
        tick(6);
    endtask

    task automatic run_frame(input string tag, input int nr, input int nc,
                             input bit en, input bit en_late,
                             output int b_wr);
        int b_st, b_dn, b_er;
        b_wr = got_q.size();
        b_st = n_start;
        b_dn = n_done;
        b_er = n_err;
        model_frame(nr, nc, en);
        drive_frame(nr, nc, en, en_late);
        chk({tag, "_nwr"}, 32'(got_q.size() - b_wr), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (b_wr + i < got_q.size())
                chk($sformatf("%s_w%0d", tag, i), got_q[b_wr+i], exp_q[i]);
        chk({tag, "_start"}, 32'(n_start - b_st), 32'(e_start));
        chk({tag, "_done"}, 32'(n_done - b_dn), 32'(e_done));
        chk({tag, "_err"}, 32'(n_err - b_er), 32'(e_err));
        chk({tag, "_cnt"}, 32'(o_frame_cnt), 32'(exp_cnt));
        chk({tag, "_ovf"}, 32'(o_overflow), 32'(exp_ovf));
    endtask

    task automatic pulse_clr();
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        tick();
        exp_ovf = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
        chk({tag, "_wr_data"}, o_wr_data, 32'd0);
        chk({tag, "_start"}, 32'(o_frame_start), 32'd0);
        chk({tag, "_done"}, 32'(o_frame_done), 32'd0);
        chk({tag, "_err"}, 32'(o_frame_err), 32'd0);
        chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
        chk({tag, "_cnt"}, 32'(o_frame_cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] nom[4];
        int b;
        int b_wr, b_st, b_dn, b_er;
        int nr, nc;
        bit en;
        nom[0] = 32'h15141312;
        nom[1] = 32'h19181716;
        nom[2] = 32'h25242322;
        nom[3] = 32'h29282726;

        rst_n = 1'b0;
        i_enable = 1'b0;
        i_frame_vsync = 1'b0;
        i_frame_href = 1'b0;
        i_frame_data = 8'd0;
        i_fifo_afull = 1'b0;
        i_ovf_clr = 1'b0;
        tick(3);
        check_zero("reset");
        rst_n = 1'b1;
        tick(4);

        fill_pattern(4, 12);
        run_frame("nominal", 4, 12, 1'b1, 1'b0, b);
        for (int i = 0; i < 4; i++)
            if (b + i < got_q.size())
                chk($sformatf("nominal_const%0d", i), got_q[b+i], nom[i]);
        if (b < got_cyc.size())
            chk("latency", 32'(got_cyc[b] - lat_cyc), 32'd1);
        else
            chk("latency_nowrite", 32'(got_cyc.size()), 32'(b + 1));

        fill_pattern(4, 12);
        for (int c = 0; c < 16; c++) afl[2][c] = 1'b1;
        run_frame("overflow", 4, 12, 1'b1, 1'b0, b);
        chk("overflow_nwr2", 32'(got_q.size() - b), 32'd2);
        chk("overflow_flag", 32'(o_overflow), 32'd1);
        chk("overflow_cnt", 32'(o_frame_cnt), 32'd1);
        pulse_clr();
        chk("ovf_clr", 32'(o_overflow), 32'd0);
        fill_pattern(4, 12);
        run_frame("after_ovf", 4, 12, 1'b1, 1'b0, b);
        chk("after_ovf_cnt", 32'(o_frame_cnt), 32'd2);

        fill_pattern(2, 12);
        run_frame("short", 2, 12, 1'b1, 1'b0, b);
        chk("short_nwr2", 32'(got_q.size() - b), 32'd2);

        fill_pattern(4, 12);
        run_frame("en_gate", 4, 12, 1'b0, 1'b1, b);
        chk("en_gate_nwr0", 32'(got_q.size() - b), 32'd0);
        run_frame("en_next", 4, 12, 1'b1, 1'b0, b);

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) pulse_clr();
            fill_random();
            nr = $urandom_range(1, 5);
            nc = $urandom_range(4, 14);
            en = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rnd%0d", k), nr, nc, en, 1'b0, b);
        end

        fill_pattern(4, 12);
        i_enable = 1'b1;
        i_frame_vsync = 1'b1;
        tick(3);
        i_frame_href = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_frame_data = pix[0][c];
            tick();
        end
        i_frame_href = 1'b0;
        tick(3);
        i_frame_href = 1'b1;
        for (int c = 0; c < 6; c++) begin
            i_frame_data = pix[1][c];
            tick();
        end
        chk("rst_pre_wr_en", 32'(o_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        exp_cnt = 16'd0;
        exp_ovf = 1'b0;
        b_wr = got_q.size();
        b_st = n_start;
        b_dn = n_done;
        b_er = n_err;
        for (int c = 6; c < 12; c++) begin
            if (c == 9) rst_n = 1'b1;
            i_frame_data = pix[1][c];
            tick();
        end
        i_frame_href = 1'b0;
        tick(3);
        for (int r = 2; r < 4; r++) begin
            i_frame_href = 1'b1;
            for (int c = 0; c < 12; c++) begin
                i_frame_data = pix[r][c];
                tick();
            end
            i_frame_href = 1'b0;
            tick(3);
        end
        i_frame_vsync = 1'b0;
        tick(6);
        chk("rst_join_nwr", 32'(got_q.size() - b_wr), 32'd0);
        chk("rst_join_start", 32'(n_start - b_st), 32'd0);
        chk("rst_join_done", 32'(n_done - b_dn), 32'd0);
        chk("rst_join_err", 32'(n_err - b_er), 32'd0);
        run_frame("rst_after", 4, 12, 1'b1, 1'b0, b);
        chk("rst_after_cnt1", 32'(o_frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
